// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-to-decode instruction bundle plus the stall/redirect feedback to fetch
//   master (fetch)  : drives i_* instruction fields, receives o_stall, o_br_taken, o_br_target
//   slave  (decode) : consumes i_* fields, drives the stall/redirect feedback
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int IMM_W = 16,
    parameter int JT_W  = 26
);
    localparam int AW = $clog2(NREG);
    logic             i_valid;
    logic [XLEN-1:0]  i_pc4;
    logic [AW-1:0]    i_rs, i_rt, i_rd;
    logic             i_use_rs, i_use_rt;
    logic [IMM_W-1:0] i_imm;
    logic [JT_W-1:0]  i_jt;
    logic             i_sign, i_wra_sel, i_we, i_is_load;
    logic [2:0]       i_brop;
    logic             o_stall, o_br_taken;
    logic [XLEN-1:0]  o_br_target;
    modport master (
        output i_valid, i_pc4, i_rs, i_rt, i_rd, i_use_rs, i_use_rt, i_imm, i_jt,
               i_sign, i_wra_sel, i_we, i_is_load, i_brop,
        input  o_stall, o_br_taken, o_br_target
    );
    modport slave (
        input  i_valid, i_pc4, i_rs, i_rt, i_rd, i_use_rs, i_use_rt, i_imm, i_jt,
               i_sign, i_wra_sel, i_we, i_is_load, i_brop,
        output o_stall, o_br_taken, o_br_target
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: ID stage with register file, EX/MEM/WB forwarding, load-use stall, decode-time branches and stall counter
//   clk, rstn        : clock, asynchronous active-low reset
//   fif (slave)      : instruction fields from fetch; stall / redirect back to fetch
//   i_ex_*, i_mem_*  : forwarding sources (an EX load has no data yet and is never forwarded)
//   i_wb_*           : register-file write port, also forwarded as write-through
//   o_*              : decoded instruction toward EX plus the saturating stall-cycle count
module decode_stage #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int IMM_W = 16,
    parameter  int JT_W  = 26,
    localparam int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rstn,
    decode_stage_if.slave    fif,
    input  logic             i_ex_we,
    input  logic             i_ex_load,
    input  logic [AW-1:0]    i_ex_addr,
    input  logic [XLEN-1:0]  i_ex_data,
    input  logic             i_mem_we,
    input  logic [AW-1:0]    i_mem_addr,
    input  logic [XLEN-1:0]  i_mem_data,
    input  logic             i_wb_we,
    input  logic [AW-1:0]    i_wb_addr,
    input  logic [XLEN-1:0]  i_wb_data,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_rd1,
    output logic [XLEN-1:0]  o_rd2,
    output logic [XLEN-1:0]  o_imm,
    output logic [AW-1:0]    o_wra,
    output logic             o_we,
    output logic             o_is_load,
    output logic [15:0]      o_stall_cnt
);
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc4;
        logic [AW-1:0]    rs;
        logic [AW-1:0]    rt;
        logic [AW-1:0]    rd;
        logic             use_rs;
        logic             use_rt;
        logic [IMM_W-1:0] imm;
        logic [JT_W-1:0]  jt;
        logic             sign;
        logic             wra_sel;
        logic             we;
        logic             is_load;
        logic [2:0]       brop;
    } dec_t;

    dec_t            r_d, w_in;
    logic [XLEN-1:0] r_rf [NREG];
    logic [15:0]     r_stall_cnt;
    logic [XLEN-1:0] w_a, w_b, w_sext, w_target;
    logic            w_stall, w_cond, w_valid, w_taken;

    always_comb begin
        w_in = '{valid: fif.i_valid, pc4: fif.i_pc4, rs: fif.i_rs, rt: fif.i_rt, rd: fif.i_rd,
                 use_rs: fif.i_use_rs, use_rt: fif.i_use_rt, imm: fif.i_imm, jt: fif.i_jt,
                 sign: fif.i_sign, wra_sel: fif.i_wra_sel, we: fif.i_we, is_load: fif.i_is_load,
                 brop: fif.i_brop};
    end

    // Youngest producer wins; WB forwarding makes a same-cycle write visible before the array updates.
    always_comb begin
        w_a = (r_d.rs == '0) ? '0 :
              (i_ex_we && !i_ex_load && i_ex_addr == r_d.rs) ? i_ex_data :
              (i_mem_we && i_mem_addr == r_d.rs) ? i_mem_data :
              (i_wb_we && i_wb_addr == r_d.rs) ? i_wb_data : r_rf[r_d.rs];
        w_b = (r_d.rt == '0) ? '0 :
              (i_ex_we && !i_ex_load && i_ex_addr == r_d.rt) ? i_ex_data :
              (i_mem_we && i_mem_addr == r_d.rt) ? i_mem_data :
              (i_wb_we && i_wb_addr == r_d.rt) ? i_wb_data : r_rf[r_d.rt];
    end

    // A stall suppresses the branch so it re-resolves next cycle with the MEM-forwarded load data.
    always_comb begin
        w_stall  = r_d.valid && i_ex_we && i_ex_load && i_ex_addr != '0 &&
                   ((r_d.use_rs && r_d.rs == i_ex_addr) || (r_d.use_rt && r_d.rt == i_ex_addr));
        w_cond   = (r_d.brop == 3'd1) ? (w_a == w_b) :
                   (r_d.brop == 3'd2) ? (w_a != w_b) :
                   (r_d.brop == 3'd3) ? (w_a[XLEN-1] || w_a == '0) :
                   (r_d.brop == 3'd4) ? (!w_a[XLEN-1] && w_a != '0) :
                   (r_d.brop == 3'd5 || r_d.brop == 3'd6);
        w_valid  = r_d.valid && !w_stall;
        w_taken  = w_valid && w_cond;
        w_sext   = {{(XLEN-IMM_W){r_d.imm[IMM_W-1]}}, r_d.imm};
        w_target = (r_d.brop >= 3'd1 && r_d.brop <= 3'd4) ? r_d.pc4 + (w_sext << 2) :
                   (r_d.brop == 3'd5) ? (((r_d.pc4 >> (JT_W + 2)) << (JT_W + 2)) | (XLEN'(r_d.jt) << 2)) :
                   (r_d.brop == 3'd6) ? w_a : '0;
    end

    assign fif.o_stall     = w_stall;
    assign fif.o_br_taken  = w_taken;
    assign fif.o_br_target = w_target;
    assign o_valid         = w_valid;
    assign o_rd1           = w_a;
    assign o_rd2           = w_b;
    assign o_imm           = r_d.sign ? w_sext : {{(XLEN-IMM_W){1'b0}}, r_d.imm};
    assign o_wra           = r_d.wra_sel ? r_d.rd : r_d.rt;
    assign o_we            = r_d.we && w_valid;
    assign o_is_load       = r_d.is_load && w_valid;
    assign o_stall_cnt     = r_stall_cnt;

    // A taken branch replaces the instruction fetched behind it with a bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_d         <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_d         <= w_taken ? '0 : w_stall ? r_d : w_in;
            r_stall_cnt <= (w_stall && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NREG; k++) r_rf[k] <= '0;
        end else if (i_wb_we && i_wb_addr != '0) begin
            r_rf[i_wb_addr] <= i_wb_data;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized run against a behavioural decode model
module tb_decode_stage;
    localparam int XLEN = 32, NREG = 32, IMM_W = 16, JT_W = 26;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [4:0]  rs, rt, rd;
        logic        use_rs, use_rt;
        logic [15:0] imm;
        logic [25:0] jt;
        logic        sign, wra_sel, we, is_load;
        logic [2:0]  brop;
    } ins_t;

    logic        clk, rstn;
    logic        ex_we, ex_load, mem_we, wb_we;
    logic [4:0]  ex_addr, mem_addr, wb_addr;
    logic [31:0] ex_data, mem_data, wb_data;
    logic        o_valid, o_we, o_is_load;
    logic [31:0] o_rd1, o_rd2, o_imm;
    logic [4:0]  o_wra;
    logic [15:0] o_stall_cnt;
    logic [31:0] m_rf [32];
    int          errors = 0, checks = 0;

    decode_stage_if #(.XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W), .JT_W(JT_W)) fif();

    decode_stage #(.XLEN(XLEN), .NREG(NREG), .IMM_W(IMM_W), .JT_W(JT_W)) dut (
        .clk(clk), .rstn(rstn), .fif(fif),
        .i_ex_we(ex_we), .i_ex_load(ex_load), .i_ex_addr(ex_addr), .i_ex_data(ex_data),
        .i_mem_we(mem_we), .i_mem_addr(mem_addr), .i_mem_data(mem_data),
        .i_wb_we(wb_we), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_valid(o_valid), .o_rd1(o_rd1), .o_rd2(o_rd2), .o_imm(o_imm), .o_wra(o_wra),
        .o_we(o_we), .o_is_load(o_is_load), .o_stall_cnt(o_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fetch(input ins_t x);
        fif.i_valid = x.valid; fif.i_pc4 = x.pc4; fif.i_rs = x.rs; fif.i_rt = x.rt; fif.i_rd = x.rd;
        fif.i_use_rs = x.use_rs; fif.i_use_rt = x.use_rt; fif.i_imm = x.imm; fif.i_jt = x.jt;
        fif.i_sign = x.sign; fif.i_wra_sel = x.wra_sel; fif.i_we = x.we; fif.i_is_load = x.is_load;
        fif.i_brop = x.brop;
    endtask

    task automatic idle();
        set_fetch('0);
        ex_we = 0; ex_load = 0; ex_addr = 0; ex_data = 0;
        mem_we = 0; mem_addr = 0; mem_data = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0;
    endtask

    // Operand value as the rules define it: r0, then EX (non-load), MEM, WB, then stored value.
    function automatic logic [31:0] res(input logic [4:0] s);
        if (s == 0) return 32'h0;
        if (ex_we && !ex_load && ex_addr == s) return ex_data;
        if (mem_we && mem_addr == s) return mem_data;
        if (wb_we && wb_addr == s) return wb_data;
        return m_rf[s];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        idle();
        rstn = 1;
        #3 rstn = 0;
        #1;
        checks++; if ({o_valid, fif.o_stall, fif.o_br_taken, o_we, o_is_load} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b want 00000", {o_valid, fif.o_stall, fif.o_br_taken, o_we, o_is_load}); end
        checks++; if (fif.o_br_target !== 32'h0) begin errors++; $display("FAIL reset_target: got %h want 0", fif.o_br_target); end
        checks++; if ({o_imm, o_wra} !== 37'h0) begin errors++; $display("FAIL reset_imm_wra: got %h/%h want 0/0", o_imm, o_wra); end
        checks++; if (o_stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", o_stall_cnt); end
        checks++; if ({o_rd1, o_rd2} !== 64'h0) begin errors++; $display("FAIL reset_rd: got %h/%h want 0/0", o_rd1, o_rd2); end
        repeat (2) cyc();
        @(negedge clk) rstn = 1;
        cyc();
    endtask

    task automatic test_regfile();
        ins_t x;
        idle();
        wb_we = 1; wb_addr = 5; wb_data = 32'h1234;
        cyc();
        wb_we = 0;
        x = '0; x.valid = 1; x.rs = 5; x.use_rs = 1;
        set_fetch(x);
        cyc(); #1;
        checks++; if (o_rd1 !== 32'h1234) begin errors++; $display("FAIL rf_read: got %h want 00001234", o_rd1); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL rf_valid: got %b want 1", o_valid); end
        x.rs = 0; set_fetch(x);
        cyc();
        wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF; #1;
        checks++; if (o_rd1 !== 32'h0) begin errors++; $display("FAIL r0_read: got %h want 0", o_rd1); end
        x.rs = 9; set_fetch(x);
        cyc();
        wb_we = 1; wb_addr = 9; wb_data = 32'h77; #1;
        checks++; if (o_rd1 !== 32'h77) begin errors++; $display("FAIL write_through: got %h want 00000077", o_rd1); end
        cyc();
        wb_we = 0; #1;
        checks++; if (o_rd1 !== 32'h77) begin errors++; $display("FAIL rf_after_wt: got %h want 00000077", o_rd1); end
        idle(); cyc();
    endtask

    task automatic test_forward();
        ins_t x;
        idle();
        x = '0; x.valid = 1; x.rs = 3; x.use_rs = 1;
        set_fetch(x);
        cyc();
        ex_we = 1; ex_addr = 3; ex_data = 32'hA;
        mem_we = 1; mem_addr = 3; mem_data = 32'hB;
        wb_we = 1; wb_addr = 3; wb_data = 32'hC; #1;
        checks++; if (o_rd1 !== 32'hA) begin errors++; $display("FAIL fwd_ex: got %h want 0000000a", o_rd1); end
        ex_we = 0; #1;
        checks++; if (o_rd1 !== 32'hB) begin errors++; $display("FAIL fwd_mem: got %h want 0000000b", o_rd1); end
        mem_we = 0; #1;
        checks++; if (o_rd1 !== 32'hC) begin errors++; $display("FAIL fwd_wb: got %h want 0000000c", o_rd1); end
        idle(); cyc();
    endtask

    task automatic test_load_use();
        ins_t x, y;
        idle();
        x = '0; x.valid = 1; x.rt = 7; x.use_rt = 1; x.we = 1;
        set_fetch(x);
        cyc();
        ex_we = 1; ex_load = 1; ex_addr = 7; ex_data = 32'h999;
        y = '0; y.valid = 1; y.rt = 2;
        set_fetch(y); #1;
        checks++; if ({fif.o_stall, o_valid, o_we} !== 3'b100) begin errors++; $display("FAIL lu_stall: got stall/valid/we %b want 100", {fif.o_stall, o_valid, o_we}); end
        checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL lu_cnt0: got %0d want 0", o_stall_cnt); end
        cyc();
        ex_we = 0; ex_load = 0;
        mem_we = 1; mem_addr = 7; mem_data = 32'h55; #1;
        checks++; if ({fif.o_stall, o_valid} !== 2'b01) begin errors++; $display("FAIL lu_release: got stall/valid %b want 01", {fif.o_stall, o_valid}); end
        checks++; if (o_rd2 !== 32'h55) begin errors++; $display("FAIL lu_mem_fwd: got %h want 00000055", o_rd2); end
        checks++; if (o_wra !== 5'd7) begin errors++; $display("FAIL lu_held: got wra %0d want 7", o_wra); end
        checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt1: got %0d want 1", o_stall_cnt); end
        mem_we = 0;
        cyc(); #1;
        checks++; if (o_wra !== 5'd2) begin errors++; $display("FAIL lu_next: got wra %0d want 2", o_wra); end
        idle(); cyc();
    endtask

    task automatic test_branches();
        ins_t x, y;
        idle();
        x = '0; x.valid = 1; x.pc4 = 32'h100; x.imm = 16'hFFFE; x.brop = 3'd1;
        set_fetch(x);
        cyc(); #1;
        checks++; if (fif.o_br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", fif.o_br_taken); end
        checks++; if (fif.o_br_target !== 32'hF8) begin errors++; $display("FAIL beq_target: got %h want 000000f8", fif.o_br_target); end
        y = '0; y.valid = 1; y.we = 1;
        set_fetch(y);
        cyc(); #1;
        checks++; if ({o_valid, o_we} !== 2'b00) begin errors++; $display("FAIL squash: got valid/we %b want 00", {o_valid, o_we}); end
        x.brop = 3'd2; set_fetch(x);
        cyc(); #1;
        checks++; if ({fif.o_br_taken, o_valid} !== 2'b01) begin errors++; $display("FAIL bne_not_taken: got taken/valid %b want 01", {fif.o_br_taken, o_valid}); end
        x.brop = 3'd3; x.rs = 1; x.use_rs = 1; set_fetch(x);
        cyc();
        mem_we = 1; mem_addr = 1; mem_data = 32'h8000_0000; #1;
        checks++; if (fif.o_br_taken !== 1'b1) begin errors++; $display("FAIL blez_taken: got %b want 1", fif.o_br_taken); end
        checks++; if (fif.o_br_target !== 32'hF8) begin errors++; $display("FAIL blez_target: got %h want 000000f8", fif.o_br_target); end
        idle(); cyc();
    endtask

    task automatic test_jumps();
        ins_t x;
        idle();
        wb_we = 1; wb_addr = 6; wb_data = 32'h2000;
        cyc();
        wb_we = 0;
        x = '0; x.valid = 1; x.brop = 3'd5; x.jt = 26'h40; x.pc4 = 32'h1000_0004;
        set_fetch(x);
        cyc(); #1;
        checks++; if (fif.o_br_taken !== 1'b1) begin errors++; $display("FAIL j_taken: got %b want 1", fif.o_br_taken); end
        checks++; if (fif.o_br_target !== 32'h1000_0100) begin errors++; $display("FAIL j_target: got %h want 10000100", fif.o_br_target); end
        x.brop = 3'd6; x.rs = 6; x.use_rs = 1; set_fetch(x);
        cyc(); #1;
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL j_squash: got valid %b want 0", o_valid); end
        cyc(); #1;
        checks++; if ({fif.o_br_taken, fif.o_br_target} !== {1'b1, 32'h2000}) begin errors++; $display("FAIL jr: got taken %b target %h want 1 00002000", fif.o_br_taken, fif.o_br_target); end
        idle(); cyc();
    endtask

    task automatic test_random();
        ins_t d, f;
        logic [31:0] a, b, e_tgt, e_imm;
        logic [4:0]  e_wra;
        logic [15:0] cnt;
        logic        e_stall, e_taken, e_valid, cond;
        int          off;
        idle();
        rstn = 0;
        @(negedge clk) rstn = 1;
        cyc();
        d = '0; cnt = 0;
        for (int k = 0; k < 32; k++) m_rf[k] = 32'h0;
        for (int n = 0; n < 600; n++) begin
            f = '0;
            f.valid = ($urandom_range(0, 3) != 0); f.pc4 = $urandom;
            f.rs = 5'($urandom_range(0, 3)); f.rt = 5'($urandom_range(0, 3)); f.rd = 5'($urandom_range(0, 31));
            f.use_rs = 1'($urandom); f.use_rt = 1'($urandom); f.imm = 16'($urandom); f.jt = 26'($urandom);
            f.sign = 1'($urandom); f.wra_sel = 1'($urandom); f.we = 1'($urandom); f.is_load = 1'($urandom);
            f.brop = 3'($urandom_range(0, 7));
            set_fetch(f);
            ex_we = 1'($urandom); ex_load = ($urandom_range(0, 3) == 0); ex_addr = 5'($urandom_range(0, 3)); ex_data = pick();
            mem_we = 1'($urandom); mem_addr = 5'($urandom_range(0, 3)); mem_data = pick();
            wb_we = 1'($urandom); wb_addr = 5'($urandom_range(0, 3)); wb_data = pick();
            #1;
            a = res(d.rs);
            b = res(d.rt);
            e_stall = d.valid && ex_we && ex_load && ex_addr != 0 &&
                      ((d.use_rs && d.rs == ex_addr) || (d.use_rt && d.rt == ex_addr));
            off = int'($signed(d.imm));
            case (d.brop)
                3'd1: cond = (a == b);
                3'd2: cond = (a != b);
                3'd3: cond = ($signed(a) <= 0);
                3'd4: cond = ($signed(a) > 0);
                3'd5, 3'd6: cond = 1'b1;
                default: cond = 1'b0;
            endcase
            case (d.brop)
                3'd1, 3'd2, 3'd3, 3'd4: e_tgt = d.pc4 + 32'(off * 4);
                3'd5: e_tgt = {d.pc4[31:28], d.jt, 2'b00};
                3'd6: e_tgt = a;
                default: e_tgt = 32'h0;
            endcase
            e_valid = d.valid && !e_stall;
            e_taken = e_valid && cond;
            e_imm = d.sign ? 32'(off) : {16'h0, d.imm};
            e_wra = d.wra_sel ? d.rd : d.rt;
            checks++; if ({o_valid, fif.o_stall, fif.o_br_taken} !== {e_valid, e_stall, e_taken}) begin errors++; $display("FAIL rnd_ctl[%0d]: got valid/stall/taken %b want %b", n, {o_valid, fif.o_stall, fif.o_br_taken}, {e_valid, e_stall, e_taken}); end
            checks++; if (fif.o_br_target !== e_tgt) begin errors++; $display("FAIL rnd_target[%0d]: got %h want %h", n, fif.o_br_target, e_tgt); end
            checks++; if ({o_rd1, o_rd2} !== {a, b}) begin errors++; $display("FAIL rnd_operands[%0d]: got %h/%h want %h/%h", n, o_rd1, o_rd2, a, b); end
            checks++; if ({o_imm, o_wra} !== {e_imm, e_wra}) begin errors++; $display("FAIL rnd_imm_wra[%0d]: got %h/%0d want %h/%0d", n, o_imm, o_wra, e_imm, e_wra); end
            checks++; if ({o_we, o_is_load} !== {d.we && e_valid, d.is_load && e_valid}) begin errors++; $display("FAIL rnd_we_load[%0d]: got %b want %b", n, {o_we, o_is_load}, {d.we && e_valid, d.is_load && e_valid}); end
            checks++; if (o_stall_cnt !== cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, o_stall_cnt, cnt); end
            cyc();
            if (e_stall && cnt != 16'hFFFF) cnt = cnt + 16'd1;
            if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
            if (e_taken) d = '0;
            else if (!e_stall) d = f;
        end
        idle(); cyc();
    endtask

    task automatic test_counter_reset();
        ins_t x;
        idle();
        wb_we = 1; wb_addr = 5; wb_data = 32'hBEEF;
        cyc();
        wb_we = 0;
        x = '0; x.valid = 1; x.rs = 7; x.use_rs = 1; x.we = 1; x.imm = 16'h8001; x.sign = 1; x.wra_sel = 1; x.rd = 9;
        set_fetch(x);
        cyc();
        ex_we = 1; ex_load = 1; ex_addr = 7;
        repeat (70000) cyc();
        checks++; if ({fif.o_stall, o_stall_cnt} !== {1'b1, 16'hFFFF}) begin errors++; $display("FAIL cnt_saturate: got stall %b cnt %h want 1 ffff", fif.o_stall, o_stall_cnt); end
        #2 rstn = 0;
        #1;
        checks++; if ({o_valid, fif.o_stall, fif.o_br_taken, o_we, o_is_load} !== 5'b0) begin errors++; $display("FAIL midreset_flags: got %b want 00000", {o_valid, fif.o_stall, fif.o_br_taken, o_we, o_is_load}); end
        checks++; if ({fif.o_br_target, o_imm, o_wra, o_stall_cnt} !== 85'h0) begin errors++; $display("FAIL midreset_values: got target %h imm %h wra %0d cnt %h want 0", fif.o_br_target, o_imm, o_wra, o_stall_cnt); end
        checks++; if ({o_rd1, o_rd2} !== 64'h0) begin errors++; $display("FAIL midreset_rd: got %h/%h want 0/0", o_rd1, o_rd2); end
        idle();
        @(negedge clk) rstn = 1;
        cyc();
        x = '0; x.valid = 1; x.rs = 5; x.use_rs = 1;
        set_fetch(x);
        cyc(); #1;
        checks++; if (o_rd1 !== 32'h0) begin errors++; $display("FAIL rf_cleared: got %h want 0", o_rd1); end
        idle(); cyc();
    endtask

    initial begin
        test_reset();
        test_regfile();
        test_forward();
        test_load_use();
        test_branches();
        test_jumps();
        test_random();
        test_counter_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
